// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control: steps each instruction through IF/ID/EX/MEM/WB and
// decodes datapath enables, mux selects and ALU control from State, Op, Func and Z.
module multi_cycle_ctrl #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic       Clk,
    input  logic       Clrn,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Z,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic [1:0] Pcsrc,
    output logic       RegWrite,
    output logic       Regrt,
    output logic       Jal,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       Aluqb,
    output logic       Se,
    output logic       Shift,
    output logic [3:0] Aluc,
    output logic [2:0] State,
    output logic       Illegal
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t state, state_nx;

    // The link register number is consumed by the datapath; zero would discard the link.
    if (RA_REG == 5'd0) begin : g_ra_guard
        $error("RA_REG must not be register zero");
    end

    logic       legal, is_ralu, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw;
    logic [3:0] alu_c;
    logic       alu_qb, alu_se, alu_sh;

    always_comb begin
        legal   = 1'b1;
        is_ralu = 1'b0;
        is_jr   = 1'b0;
        is_j    = 1'b0;
        is_jal  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        alu_c   = 4'b0000;
        alu_qb  = 1'b0;
        alu_se  = 1'b0;
        alu_sh  = 1'b0;
        case (Op)
            6'b000000: begin
                is_ralu = 1'b1;
                alu_qb  = 1'b1;
                case (Func)
                    6'b100000: alu_c = 4'b0000;
                    6'b100010: alu_c = 4'b0100;
                    6'b100100: alu_c = 4'b0001;
                    6'b100101: alu_c = 4'b0101;
                    6'b100110: alu_c = 4'b0010;
                    6'b000000: begin alu_c = 4'b0011; alu_sh = 1'b1; end
                    6'b000010: begin alu_c = 4'b0111; alu_sh = 1'b1; end
                    6'b000011: begin alu_c = 4'b1111; alu_sh = 1'b1; end
                    6'b001000: begin is_jr = 1'b1; is_ralu = 1'b0; alu_qb = 1'b0; end
                    default:   begin legal = 1'b0; is_ralu = 1'b0; alu_qb = 1'b0; end
                endcase
            end
            6'b001000: begin alu_c = 4'b0000; alu_se = 1'b1; end
            6'b001100: alu_c = 4'b0001;
            6'b001101: alu_c = 4'b0101;
            6'b001110: alu_c = 4'b0010;
            6'b001111: alu_c = 4'b0110;
            6'b100011: begin is_lw = 1'b1; alu_se = 1'b1; end
            6'b101011: begin is_sw = 1'b1; alu_se = 1'b1; end
            6'b000100: begin is_beq = 1'b1; alu_c = 4'b0100; alu_qb = 1'b1; alu_se = 1'b1; end
            6'b000101: begin is_bne = 1'b1; alu_c = 4'b0100; alu_qb = 1'b1; alu_se = 1'b1; end
            6'b000010: is_j = 1'b1;
            6'b000011: is_jal = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) state <= S_IF;
        else       state <= state_nx;
    end

    logic pcw, irw, rw, mw, ill;

    always_comb begin
        state_nx = S_IF;
        pcw      = 1'b0;
        irw      = 1'b0;
        rw       = 1'b0;
        mw       = 1'b0;
        ill      = 1'b0;
        Pcsrc    = 2'b00;
        Regrt    = 1'b0;
        Jal      = 1'b0;
        MemtoReg = 1'b0;
        Aluqb    = 1'b0;
        Se       = 1'b0;
        Shift    = 1'b0;
        Aluc     = 4'b0000;
        case (state)
            S_IF: begin
                irw      = 1'b1;
                pcw      = 1'b1;
                state_nx = S_ID;
            end
            S_ID: begin
                if (!legal) begin
                    ill = 1'b1;
                end else if (is_j || is_jal) begin
                    pcw   = 1'b1;
                    Pcsrc = 2'b11;
                    rw    = is_jal;
                    Jal   = is_jal;
                end else if (is_jr) begin
                    pcw   = 1'b1;
                    Pcsrc = 2'b10;
                end else begin
                    state_nx = S_EX;
                end
            end
            S_EX: begin
                Aluc  = alu_c;
                Aluqb = alu_qb;
                Se    = alu_se;
                Shift = alu_sh;
                if (is_beq || is_bne) begin
                    pcw   = is_beq ? Z : ~Z;
                    Pcsrc = 2'b01;
                end else if (is_lw || is_sw) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                Aluc  = alu_c;
                Aluqb = alu_qb;
                Se    = alu_se;
                Shift = alu_sh;
                if (is_sw) mw = 1'b1;
                else       state_nx = S_WB;
            end
            S_WB: begin
                Aluc     = alu_c;
                Aluqb    = alu_qb;
                Se       = alu_se;
                Shift    = alu_sh;
                rw       = 1'b1;
                Regrt    = ~is_ralu;
                MemtoReg = is_lw;
            end
            default: state_nx = S_IF;
        endcase
    end

    // Reset holds every write off combinationally so an abandoned instruction leaves no trace.
    assign PCWrite  = pcw & Clrn;
    assign IRWrite  = irw & Clrn;
    assign RegWrite = rw  & Clrn;
    assign MemWrite = mw  & Clrn;
    assign Illegal  = ill & Clrn;
    assign State    = state;
endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Multi-cycle control FSM that sequences the MIPS datapath around the 32-word instruction ROM and data memory. It steps every instruction through the IF/ID/EX/MEM/WB phases and issues write enables, mux selects and ALU control each cycle. It replaces the single-cycle combinational control unit so the ROM, ALU and memory can share one datapath across cycles. It supports the ISA subset in the instruction ROM: add/sub/and/or/xor/sll/srl/sra/jr, addi/andi/ori/xori/lui, lw/sw, beq/bne, j/jal.

Parameters:
RA_REG, 5'd31, destination register number for jal link.

Ports:
Clk  input  1  system clock, rising edge
Clrn  input  1  synchronous active-low reset
Op  input  6  opcode field Inst[31:26], held in IR by datapath
Func  input  6  function field Inst[5:0]
Z  input  1  ALU zero flag, valid in EX
PCWrite  output  1  PC register load enable
IRWrite  output  1  IR load enable (latches ROM output)
Pcsrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 rs (jr), 11 jump target
RegWrite  output  1  register file write enable
Regrt  output  1  1 = destination rt, 0 = rd
Jal  output  1  1 = write PC+4 to RA_REG
MemtoReg  output  1  1 = writeback from data memory
MemWrite  output  1  data memory write enable
Aluqb  output  1  1 = ALU B from register, 0 = extended immediate
Se  output  1  1 = sign-extend immediate, 0 = zero-extend
Shift  output  1  1 = ALU A from shamt
Aluc  output  4  ALU op: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111
State  output  3  current state, for debug
Illegal  output  1  one-cycle pulse in ID on unsupported Op/Func

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. State is the only register; all other outputs decode combinationally from State, Op, Func and Z.
- Reset: when Clrn=0 at a rising edge, State<=IF. While Clrn=0, force PCWrite, IRWrite, RegWrite, MemWrite and Illegal to 0. Reset mid-instruction abandons it with no partial write.
- IF: IRWrite=1, PCWrite=1, Pcsrc=00. Next state ID.
- ID:
  - j: PCWrite=1, Pcsrc=11.
  - jal: adds RegWrite=1 and Jal=1 (link to RA_REG).
  - jr (Op=0, Func=001000): PCWrite=1, Pcsrc=10.
  - All three return to IF, so jumps take 2 cycles.
  - Unsupported encoding: Illegal=1, return to IF, no writes.
  - Otherwise go to EX.
- EX: Aluc, Aluqb, Se and Shift are driven for the instruction.
  - beq: PCWrite=Z, Pcsrc=01, Aluc=sub, then IF (3 cycles).
  - bne: PCWrite=~Z, otherwise as beq.
  - lw/sw: Aluc=add, Aluqb=0, Se=1, then MEM.
  - R-type and I-type ALU instructions: go to WB.
- MEM: hold the EX ALU controls.
  - sw: MemWrite=1 for exactly this cycle, then IF (4 cycles).
  - lw: go to WB.
- WB: RegWrite=1 for exactly one cycle, holding the ALU controls. MemtoReg=1 for lw only. Regrt=1 for I-type/lw, 0 for R-type. Next state IF. R/I-type take 4 cycles, lw takes 5.
- Immediate extension: Se=1 for addi/lw/sw/beq/bne; Se=0 for andi/ori/xori/lui.
- Shift=1 only for sll/srl/sra.
- Undriven selects default to 0 in every state. No write enable is asserted outside the states listed above.
- State values 5-7 are unreachable; if entered, go to IF with no writes.

Test Plan:
- Reset: Clrn=0 for 2 cycles, then release -> State=0, IRWrite=1, PCWrite=1, all other enables 0.
- addi (Op=001000) -> states 0,1,2,4; in EX Aluc=0000, Aluqb=0, Se=1; RegWrite=1 only in state 4 with Regrt=1.
- R-type sll (Op=0, Func=000000) -> Shift=1, Aluc=0011, Regrt=0; 4 cycles.
- lw (100011) -> 5 cycles, MemtoReg=1 in WB. sw (101011) -> MemWrite=1 only in MEM, RegWrite never asserted, 4 cycles.
- beq with Z=1 -> PCWrite=1, Pcsrc=01 in EX. Same with Z=0 -> PCWrite=0. bne with Z=0 -> PCWrite=1. Each completes in 3 cycles.
- jal (000011) -> in ID: PCWrite=1, Pcsrc=11, RegWrite=1, Jal=1; back to IF after 2 cycles.
- jr (Op=0, Func=001000) -> Pcsrc=10 in ID.
- Op=111111 -> Illegal=1 for one cycle in ID, then IF.
- Clrn=0 during MEM of sw -> MemWrite=0 in that cycle; State=0 next cycle.
